jtframe_romcache: RTL and testbench
===================================

# jtframe_romcache

Multi-line read cache placed between a core's ROM port and one SDRAM bank slot. It succeeds the single-word ROM request block. It keeps LINES 32-bit SDRAM words with their tags, answers hits in the same cycle, and issues one word-aligned SDRAM request per miss. Lines are replaced round-robin, and a flush input invalidates the whole cache. Sequential prefetch of the next word is optional.

## Interface
Parameters:
- AW, 18, core address width in DW-sized units.
- DW, 8, core data width: 8, 16 or 32.
- LINES, 4, cache lines; power of two, 1..16.
- INVERT_A0, 0, when 1 and DW==8, swap the bytes within each 16-bit half.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- cen  in  1  clock enable for lookups and new requests.
- clr  in  1  invalidate all lines.
- addr  in  AW  core address.
- addr_ok  in  1  addr is valid.
- din  in  32  SDRAM read data.
- din_ok  in  1  SDRAM data valid.
- we  in  1  slot acknowledge; a fill happens only when din_ok and we are both high.
- req  out  1  SDRAM request; held high until the fill.
- addr_req  out  AW  word-aligned request address; low log2(32/DW) bits are zero.
- data_ok  out  1  dout is valid for the current addr.
- dout  out  DW  read data.

## Operation
- Word index W is addr shifted right by log2(32/DW). The sub-word select is the low bits of addr; for DW==8, bit 0 is inverted when INVERT_A0 is set.
- Each line holds valid, tag (W) and data (32 bits).
- Hit = addr_ok and a valid line with tag==W. Hit logic is combinational. dout is the selected slice of the hitting line.
- States:
  - IDLE: on cen, addr_ok and a miss, latch addr_req={W,0s}, set req=1, go to FILL.
  - FILL: on din_ok and we, write din, tag and valid=1 into the line at the victim pointer. Then advance the victim pointer (modulo LINES), drop req, go to IDLE.
- A fill in progress always completes, even if addr changes meanwhile. The new address is looked up again in the cycle after the fill.
- Hits on other lines are still served while in FILL.
- clr clears every valid bit in one cycle.
  - If clr arrives during FILL, the state machine still waits for din_ok but discards the data. The line is not written and the victim pointer does not advance.
  - clr together with din_ok: clr wins.
- din_ok without we is ignored.

## Timing
- Reset values: req=0, addr_req=0, data_ok=0, dout=0 while rst is high. All lines invalid, victim pointer=0, state IDLE.
- rst during FILL aborts the request: req=0 on the next cycle, and a late din_ok is ignored.
- Hit latency: 0 cycles. data_ok and dout are valid in the same cycle as addr/addr_ok.
- Miss:
  - req rises on the clock edge after the cycle that saw the miss with cen=1.
  - The fill writes on the din_ok&we edge; req is 0 after that edge.
  - data_ok rises in the cycle after the fill edge.
- The earliest next request is issued 1 cycle after a fill.
- cen=0 blocks starting new requests. It does not gate fills or hit reporting.

## Configuration
- JTFRAME_ROMCACHE_PREFETCH_EN defined:
  - After a demand fill of word W, if W+1 is not cached and there is no demand miss in that cycle, issue req for W+1 (state PREFETCH). The prefetched word fills like a normal miss and advances the victim pointer.
  - W+1 wraps to 0 at the top of the address space.
  - A demand miss that arrives during PREFETCH waits until the prefetch fill completes.
  - A prefetch never chains into a further prefetch.
- Not defined: the PREFETCH state does not exist, and requests are issued only on demand misses.

## Test plan
- Reset, then addr=0x100 with addr_ok=1, DW=8: req=1 with addr_req=0x100. Return din=0x44332211 → data_ok=1 and dout=0x11. Then addr=0x103 → hit in the same cycle, dout=0x44 (INVERT_A0=0).
- LINES=4: miss on words 0..4 in sequence. The fifth fill replaces line 0. Re-reading word 0 raises req again, while word 1 still hits.
- Miss on word 8, then change addr to word 9 during FILL. Word 8 fills, and req for word 9 rises 1 cycle later. A hit on an already-cached word during FILL returns data_ok=1.
- clr during FILL, followed by din_ok: no line becomes valid, and re-reading the address issues req again. clr and din_ok in the same cycle behave the same way.
- rst asserted during FILL, followed by a late din_ok: req=0, data_ok=0, nothing cached.
- With JTFRAME_ROMCACHE_PREFETCH_EN: miss on the top word → fill, then req for word 0 (wrap). The next read of word 0 hits with no further req.

Source files
------------

// File: rtl/jtframe_romcache_if.sv
// Core/SDRAM-side bus of the ROM read cache: lookup, flush, fill handshake and read data.
interface jtframe_romcache_if #(
  parameter int AW = 18,
  parameter int DW = 8
);
  logic          cen;
  logic          clr;
  logic [AW-1:0] addr;
  logic          addr_ok;
  logic [31:0]   din;
  logic          din_ok;
  logic          we;
  logic          req;
  logic [AW-1:0] addr_req;
  logic          data_ok;
  logic [DW-1:0] dout;

  modport master (output cen, clr, addr, addr_ok, din, din_ok, we,
                  input  req, addr_req, data_ok, dout);
  modport slave  (input  cen, clr, addr, addr_ok, din, din_ok, we,
                  output req, addr_req, data_ok, dout);
endinterface

// File: rtl/jtframe_romcache.sv
// Multi-line round-robin ROM read cache in front of one SDRAM slot; same-cycle hits.
// Optional next-word prefetch: define JTFRAME_ROMCACHE_PREFETCH_EN.
module jtframe_romcache #(
  parameter int AW        = 18,
  parameter int DW        = 8,
  parameter int LINES     = 4,
  parameter int INVERT_A0 = 0
) (
  input  logic               clk,
  input  logic               rst,
  jtframe_romcache_if.slave  bus
);
  localparam int SW  = $clog2(32 / DW);
  localparam int WAW = AW - SW;
  localparam int VW  = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
    , PREFETCH
`endif
  } state_t;

  state_t                      state_q, state_d;
  logic                        req_q, req_d;
  logic [WAW-1:0]              reqw_q, reqw_d;
  logic                        disc_q, disc_d;
  logic [VW-1:0]               victim_q, victim_d;
  logic [LINES-1:0]            vld_q, vld_d;
  logic [LINES-1:0][WAW-1:0]   tag_q;
  logic [LINES-1:0][31:0]      data_q;

  logic [WAW-1:0] word;
  logic           tag_hit, hit, wr_en, fill_ok;
  logic [31:0]    hdata;
  logic [4:0]     shamt;

  assign word = bus.addr[AW-1:SW];

  generate
    if (SW > 0) begin : g_sub
      logic [SW-1:0] sub;
      always_comb begin
        sub = bus.addr[SW-1:0];
        if (INVERT_A0 != 0 && DW == 8) sub[0] = ~sub[0];
      end
      assign shamt = 5'(sub) << $clog2(DW);
    end else begin : g_nosub
      assign shamt = '0;
    end
  endgenerate

  always_comb begin
    tag_hit = 1'b0;
    hdata   = '0;
    for (int i = 0; i < LINES; i++) begin
      if (vld_q[i] && tag_q[i] == word) begin
        tag_hit = 1'b1;
        hdata   = data_q[i];
      end
    end
    hit = tag_hit & bus.addr_ok;
  end

  assign bus.data_ok  = hit & ~rst;
  assign bus.dout     = (rst || !hit) ? '0 : hdata[shamt +: DW];
  assign bus.req      = req_q & ~rst;
  assign bus.addr_req = rst ? '0 : (AW'(reqw_q) << SW);

  // A flush seen at any point of a fill poisons the returning data
  assign fill_ok = bus.din_ok & bus.we & ~bus.clr & ~disc_q;

`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
  logic [WAW-1:0] pf_word;
  logic           pf_hit, dmiss;
  assign pf_word = reqw_q + WAW'(1);
  // The victim line is being overwritten now, so its old tag does not count
  always_comb begin
    pf_hit = 1'b0;
    for (int i = 0; i < LINES; i++)
      if (vld_q[i] && tag_q[i] == pf_word && VW'(i) != victim_q) pf_hit = 1'b1;
  end
  assign dmiss = bus.cen & bus.addr_ok & ~hit & (word != reqw_q);
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    reqw_d   = reqw_q;
    disc_d   = disc_q | bus.clr;
    victim_d = victim_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        disc_d = 1'b0;
        if (bus.cen && bus.addr_ok && !hit) begin
          state_d = FILL;
          req_d   = 1'b1;
          reqw_d  = word;
        end
      end
      FILL: begin
        if (bus.din_ok && bus.we) begin
          state_d = IDLE;
          req_d   = 1'b0;
          disc_d  = 1'b0;
          if (fill_ok) begin
            wr_en    = 1'b1;
            victim_d = (victim_q == VW'(LINES - 1)) ? '0 : victim_q + VW'(1);
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
            if (!pf_hit && !dmiss) begin
              state_d = PREFETCH;
              req_d   = 1'b1;
              reqw_d  = pf_word;
            end
`endif
          end
        end
      end
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
      PREFETCH: begin
        if (bus.din_ok && bus.we) begin
          state_d = IDLE;
          req_d   = 1'b0;
          disc_d  = 1'b0;
          if (fill_ok) begin
            wr_en    = 1'b1;
            victim_d = (victim_q == VW'(LINES - 1)) ? '0 : victim_q + VW'(1);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d = vld_q;
    if (wr_en) vld_d[victim_q] = 1'b1;
    if (bus.clr) vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      reqw_q   <= '0;
      disc_q   <= 1'b0;
      victim_q <= '0;
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      reqw_q   <= reqw_d;
      disc_q   <= disc_d;
      victim_q <= victim_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_q[victim_q]  <= reqw_q;
      data_q[victim_q] <= bus.din;
    end
  end
endmodule

// File: tb/tb_jtframe_romcache.sv
// Bench for jtframe_romcache: directed test-plan sequences plus random traffic vs. a cache model.
module tb_jtframe_romcache;
  localparam int AW = 18, DW = 8, LINES = 4, SW = 2, WAW = AW - SW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtframe_romcache_if #(.AW(AW), .DW(DW)) bus();
  jtframe_romcache #(.AW(AW), .DW(DW), .LINES(LINES), .INVERT_A0(0)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int checks = 0, failures = 0;

  logic          d_rst, d_cen, d_clr, d_aok, d_dok, d_we;
  logic [AW-1:0] d_addr;

  // model: slot contents, round-robin pointer, outstanding request
  logic [LINES-1:0] m_v;
  logic [WAW-1:0]   m_w [LINES];
  int               m_ptr;
  logic             m_pend, m_disc, m_pf;
  logic [WAW-1:0]   m_pw;

  logic          o_ok, o_req;
  logic [DW-1:0] o_dout;
  logic [AW-1:0] o_areq;

  function automatic logic [31:0] mem(input logic [WAW-1:0] w);
    if (w == 16'h0040) return 32'h44332211;
    return {w, ~w} ^ 32'hA5C3_0F96;
  endfunction

  function automatic int m_find(input logic [WAW-1:0] w);
    for (int i = 0; i < LINES; i++) if (m_v[i] && m_w[i] == w) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [WAW-1:0] w;
    logic [31:0]    ed;
    logic           hit, dmiss;
    int             sub;
    @(negedge clk);
    rst         = d_rst;
    bus.cen     = d_cen;
    bus.clr     = d_clr;
    bus.addr    = d_addr;
    bus.addr_ok = d_aok;
    bus.din_ok  = d_dok;
    bus.we      = d_we;
    bus.din     = mem(m_pw);
    #1;
    w   = d_addr[AW-1:SW];
    sub = int'(d_addr[SW-1:0]);
    hit = !d_rst && d_aok && (m_find(w) >= 0);
    ed  = mem(w);
    o_ok = bus.data_ok; o_dout = bus.dout; o_req = bus.req; o_areq = bus.addr_req;
    chk("data_ok", 32'(o_ok), 32'(hit));
    chk("dout", 32'(o_dout), hit ? 32'(ed[sub*8 +: 8]) : 32'd0);
    chk("req", 32'(o_req), 32'(!d_rst && m_pend));
    chk("addr_req", 32'(o_areq), d_rst ? 32'd0 : 32'({m_pw, 2'b00}));
    @(posedge clk);
    if (d_rst) begin
      m_v = '0; m_ptr = 0; m_pend = 0; m_disc = 0; m_pf = 0; m_pw = '0;
    end else begin
      dmiss = d_cen && d_aok && !hit;
      if (m_pend) begin
        if (d_clr) m_disc = 1'b1;
        if (d_dok && d_we) begin
          m_pend = 1'b0;
          if (!m_disc) begin
            m_v[m_ptr] = 1'b1;
            m_w[m_ptr] = m_pw;
            m_ptr = (m_ptr + 1) % LINES;
`ifdef JTFRAME_ROMCACHE_PREFETCH_EN
            if (!m_pf && m_find(m_pw + 16'd1) < 0 && !(dmiss && w != m_pw)) begin
              m_pend = 1'b1; m_pf = 1'b1; m_pw = m_pw + 16'd1;
            end else m_pf = 1'b0;
`endif
          end else m_pf = 1'b0;
          m_disc = 1'b0;
        end
      end else if (dmiss) begin
        m_pend = 1'b1; m_pw = w; m_disc = 1'b0; m_pf = 1'b0;
      end
      if (d_clr) m_v = '0;
    end
  endtask

  task automatic fill_word(input logic [WAW-1:0] w);
    d_addr = {w, 2'b00}; d_cen = 1; step();
    d_dok = 1; step(); d_dok = 0;
  endtask

  task automatic peek(input logic [WAW-1:0] w);
    d_cen = 0; d_addr = {w, 2'b00}; step(); d_cen = 1;
  endtask

  initial begin
    d_rst = 1; d_cen = 1; d_clr = 0; d_aok = 1; d_dok = 0; d_we = 1; d_addr = '0;
    m_v = '0; m_ptr = 0; m_pend = 0; m_disc = 0; m_pf = 0; m_pw = '0;
    for (int i = 0; i < LINES; i++) m_w[i] = '0;
    step(); step();
    chk("rst_req", 32'(o_req), 32'd0);
    chk("rst_data_ok", 32'(o_ok), 32'd0);
    d_rst = 0;
`ifndef JTFRAME_ROMCACHE_PREFETCH_EN
    d_addr = 18'h100; step();
    step(); chk("tp1_req", 32'(o_req), 32'd1); chk("tp1_areq", 32'(o_areq), 32'h100);
    d_dok = 1; step(); d_dok = 0;
    step(); chk("tp1_ok", 32'(o_ok), 32'd1); chk("tp1_dout", 32'(o_dout), 32'h11);
    d_addr = 18'h103; step(); chk("tp1_hit3", 32'(o_dout), 32'h44);

    d_clr = 1; step(); d_clr = 0;
    for (int w = 0; w < 5; w++) fill_word(WAW'(w));
    peek(0); chk("evict_w0", 32'(o_ok), 32'd0);
    peek(1); chk("keep_w1", 32'(o_ok), 32'd1);
    d_addr = 18'h0; step();
    step(); chk("evict_req", 32'(o_req), 32'd1);
    d_dok = 1; step(); d_dok = 0;

    d_addr = {16'd8, 2'b00}; step();
    d_addr = {16'd4, 2'b01}; step(); chk("fill_hit", 32'(o_ok), 32'd1);
    d_addr = {16'd9, 2'b00}; d_dok = 1; step(); d_dok = 0;
    step(); chk("w9_req0", 32'(o_req), 32'd0);
    step(); chk("w9_req1", 32'(o_req), 32'd1); chk("w9_areq", 32'(o_areq), 32'h24);
    d_dok = 1; step(); d_dok = 0;

    d_addr = {16'd20, 2'b00}; step();
    d_clr = 1; step(); d_clr = 0;
    d_dok = 1; step(); d_dok = 0;
    peek(20); chk("clr_fill", 32'(o_ok), 32'd0);
    d_addr = {16'd20, 2'b00}; step();
    step(); chk("clr_rereq", 32'(o_req), 32'd1);
    d_clr = 1; d_dok = 1; step(); d_clr = 0; d_dok = 0;
    peek(20); chk("clr_dok", 32'(o_ok), 32'd0);

    d_addr = {16'd30, 2'b00}; step(); step();
    d_rst = 1; step(); d_rst = 0;
    d_cen = 0; d_dok = 1; step(); d_dok = 0; d_cen = 1;
    chk("rst_abort_req", 32'(o_req), 32'd0);
    peek(30); chk("rst_abort_ok", 32'(o_ok), 32'd0);
`else
    d_addr = {16'hFFFF, 2'b00}; step();
    d_dok = 1; step(); d_dok = 0;
    step(); chk("pf_req", 32'(o_req), 32'd1); chk("pf_areq", 32'(o_areq), 32'd0);
    d_dok = 1; step(); d_dok = 0;
    d_addr = 18'h0; step(); chk("pf_hit", 32'(o_ok), 32'd1); chk("pf_noreq", 32'(o_req), 32'd0);
`endif

    repeat (3000) begin
      d_rst = ($urandom % 200) == 0;
      d_cen = ($urandom % 5) != 0;
      d_clr = ($urandom % 40) == 0;
      d_aok = ($urandom % 5) != 0;
      d_dok = m_pend ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
      d_we  = ($urandom % 7) != 0;
      d_addr = {(($urandom % 12) == 0) ? 16'hFFFF : 16'($urandom % 10), 2'($urandom)};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
